// File: rtl/clk_skew_monitor.sv
// Clock presence/frequency/skew monitor: NUM_CH asynchronous clocks sampled as data in clkIn, ch0 is the reference.
// Optional sticky error flag is enabled by defining CLK_MON_STICKY_ERR_EN.
module clk_skew_monitor #(
  parameter int NUM_CH      = 2,
  parameter int GATE_CYCLES = 800,
  parameter int CNT_W       = 16,
  parameter int SKEW_W      = 8,
  parameter int CNT_MIN     = 95,
  parameter int CNT_MAX     = 105,
  parameter int SKEW_MIN    = 1,
  parameter int SKEW_MAX    = 4,
  parameter int ARM_TIMEOUT = 256
) (
  input  logic                         clkIn,
  input  logic                         rstBIn,
  input  logic [NUM_CH-1:0]            monClkIn,
  input  logic                         startIn,
  input  logic                         clrErrIn,
  output logic                         busyOut,
  output logic                         doneOut,
  output logic                         timeoutOut,
  output logic [NUM_CH*CNT_W-1:0]      edgeCntOut,
  output logic [NUM_CH-1:0]            freqOkOut,
  output logic [(NUM_CH-1)*SKEW_W-1:0] skewOut,
  output logic [NUM_CH-2:0]            skewOkOut,
  output logic                         errOut
);

  localparam int gateW = $clog2(GATE_CYCLES + 1);
  localparam int toW   = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  cntSat   = '1;
  localparam logic [SKEW_W-1:0] skewSat  = '1;
  localparam logic [CNT_W-1:0]  cntMinV  = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0]  cntMaxV  = CNT_W'(CNT_MAX);
  localparam logic [SKEW_W-1:0] skewMinV = SKEW_W'(SKEW_MIN);
  localparam logic [SKEW_W-1:0] skewMaxV = SKEW_W'(SKEW_MAX);

  typedef enum logic [1:0] {Idle, Arm, Measure, Done} stateT;

  stateT                          state;
  logic [NUM_CH-1:0]              sync1, sync2, prevSync, edgeDet;
  logic [NUM_CH-1:0][CNT_W-1:0]   edgeCnt, nextCnt;
  logic [NUM_CH-1:1][SKEW_W-1:0]  skewCnt, nextSkew;
  logic [NUM_CH-1:1]              skewRun, nextRun;
  logic [NUM_CH-1:0]              freqOkNext;
  logic [NUM_CH-2:0]              skewOkNext;
  logic [gateW-1:0]               gateCnt;
  logic [toW-1:0]                 toCnt;

  assign edgeCntOut = edgeCnt;
  assign skewOut    = skewCnt;

  // Same three-flop depth on every channel, so relative skew survives synchronisation.
  // NOTE: async reset in the sensitivity list; every flop here is plain logic, no memories to leave unreset.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      sync1    <= '0;
      sync2    <= '0;
      prevSync <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      sync1    <= monClkIn;
      sync2    <= sync1;
      prevSync <= sync2;
    end
  end

  assign edgeDet = sync2 & ~prevSync;

  // The ARM cycle that sees the ch0 edge is the first measurement cycle.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    nextCnt    = edgeCnt;
    nextSkew   = skewCnt;
    nextRun    = skewRun;
    freqOkNext = '0;
    skewOkNext = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (state == Arm)
        nextCnt[ch] = CNT_W'(edgeDet[ch]);
      else if (edgeDet[ch] && edgeCnt[ch] != cntSat)
        nextCnt[ch] = edgeCnt[ch] + 1'b1;
      freqOkNext[ch] = (nextCnt[ch] >= cntMinV) && (nextCnt[ch] <= cntMaxV);
    end
    for (int n = 1; n < NUM_CH; n++) begin
      if (state == Arm) begin
        nextSkew[n] = SKEW_W'(1);
        nextRun[n]  = 1'b1;
      end else if (skewRun[n]) begin
        if (edgeDet[n])
          nextRun[n] = 1'b0;
        else if (skewCnt[n] != skewSat)
          nextSkew[n] = skewCnt[n] + 1'b1;
      end
      skewOkNext[n-1] = !nextRun[n] && (nextSkew[n] != skewSat) &&
                        (nextSkew[n] >= skewMinV) && (nextSkew[n] <= skewMaxV);
    end
  end

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state      <= Idle;
      busyOut    <= 1'b0;
      doneOut    <= 1'b0;
      timeoutOut <= 1'b0;
      freqOkOut  <= '0;
      skewOkOut  <= '0;
      edgeCnt    <= '0;
      skewCnt    <= '0;
      skewRun    <= '0;
      gateCnt    <= '0;
      toCnt      <= '0;
    end else begin
      case (state)
        Idle: begin
          if (startIn) begin
            state      <= Arm;
            busyOut    <= 1'b1;
            timeoutOut <= 1'b0;
            freqOkOut  <= '0;
            skewOkOut  <= '0;
            edgeCnt    <= '0;
            skewCnt    <= '0;
            skewRun    <= '0;
            toCnt      <= toW'(ARM_TIMEOUT - 1);
          end
        end
        Arm: begin
          if (edgeDet[0]) begin
            state   <= Measure;
            edgeCnt <= nextCnt;
            skewCnt <= nextSkew;
            skewRun <= nextRun;
            gateCnt <= gateW'(GATE_CYCLES - 2);
          end else if (toCnt == '0) begin
            state      <= Done;
            doneOut    <= 1'b1;
            timeoutOut <= 1'b1;
          end else begin
            toCnt <= toCnt - 1'b1;
          end
        end
        Measure: begin
          edgeCnt <= nextCnt;
          skewCnt <= nextSkew;
          skewRun <= nextRun;
          if (gateCnt == '0) begin
            state     <= Done;
            doneOut   <= 1'b1;
            freqOkOut <= freqOkNext;
            skewOkOut <= skewOkNext;
          end else begin
            gateCnt <= gateCnt - 1'b1;
          end
        end
        Done: begin
          state   <= Idle;
          doneOut <= 1'b0;
          busyOut <= 1'b0;
        end
        default: state <= Idle;
      endcase
    end
  end

`ifdef CLK_MON_STICKY_ERR_EN
  logic errSet;
  assign errSet = (state == Done) && (timeoutOut || !(&freqOkOut) || !(&skewOkOut));

  // A failing result in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn)
      errOut <= 1'b0;
    else if (errSet)
      errOut <= 1'b1;
    else if (clrErrIn)
      errOut <= 1'b0;
  end
`else
  logic unusedClrErr;
  assign unusedClrErr = clrErrIn;
  assign errOut       = 1'b0;
`endif

endmodule

// File: tb/tb_clk_skew_monitor.sv
// Bench for clk_skew_monitor: a 2-channel and a 4-channel instance share stimulus and are
// compared against an edge-list model of the monitored waveforms.
module tb_clk_skew_monitor;

  localparam int G       = 800;
  localparam int TO      = 256;
  localparam int SKEW_SAT = 255;
`ifdef CLK_MON_STICKY_ERR_EN
  localparam bit StickyEn = 1'b1;
`else
  localparam bit StickyEn = 1'b0;
`endif

  logic clkIn = 1'b0;
  logic rstBIn, startIn, clrErrIn;
  logic [3:0] monClkIn = '0;

  logic busyA, doneA, toA, errA;
  logic [31:0] cntA;
  logic [1:0]  fokA;
  logic [7:0]  skA;
  logic [0:0]  sokA;
  logic busyB, doneB, toB, errB;
  logic [63:0] cntB;
  logic [3:0]  fokB;
  logic [23:0] skB;
  logic [2:0]  sokB;

  int perCh[4];
  int dlyCh[4];
  int nChecks = 0;
  int nFails  = 0;
  bit errExpA = 1'b0;
  bit errExpB = 1'b0;

  longint expDone;
  bit     expTo;
  int     expCnt[4];
  int     expSkew[4];
  bit     expFok[4];
  bit     expSok[4];

  clk_skew_monitor dutA (
    .clkIn(clkIn), .rstBIn(rstBIn), .monClkIn(monClkIn[1:0]), .startIn(startIn),
    .clrErrIn(clrErrIn), .busyOut(busyA), .doneOut(doneA), .timeoutOut(toA),
    .edgeCntOut(cntA), .freqOkOut(fokA), .skewOut(skA), .skewOkOut(sokA), .errOut(errA)
  );

  clk_skew_monitor #(.NUM_CH(4)) dutB (
    .clkIn(clkIn), .rstBIn(rstBIn), .monClkIn(monClkIn), .startIn(startIn),
    .clrErrIn(clrErrIn), .busyOut(busyB), .doneOut(doneB), .timeoutOut(toB),
    .edgeCntOut(cntB), .freqOkOut(fokB), .skewOut(skB), .skewOkOut(sokB), .errOut(errB)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle k starts at the posedge at time 10k+5; at a negedge this returns the cycle just begun.
  function automatic longint cycNow();
    return longint'($time / 10) - 1;
  endfunction

  // Monitored clock ch at sample tick k: period perCh ticks, rising at k = dlyCh (mod perCh).
  function automatic bit wave(int ch, longint k);
    longint m;
    if (perCh[ch] == 0 || k < 0) return 1'b0;
    m = k - dlyCh[ch] + 100 * perCh[ch];
    return (m % perCh[ch]) < (perCh[ch] / 2);
  endfunction

  function automatic bit rise(int ch, longint k);
    return wave(ch, k) && !wave(ch, k - 1);
  endfunction

  always @(negedge clkIn)
    for (int ch = 0; ch < 4; ch++) monClkIn[ch] = wave(ch, cycNow());

  // Expected results for a startIn driven during cycle t. The bench sees a rise at tick r
  // in the monitor as a fixed-latency event, so the measurement covers rises [s, s+G-1].
  task automatic modelRun(input longint t);
    longint s;
    bit     found;
    int     cnt;
    int     sk;
    s = -1;
    found = 1'b0;
    for (longint r = t - 1; r <= t + TO - 2 && !found; r++)
      if (rise(0, r)) begin
        s = r;
        found = 1'b1;
      end
    expTo = !found;
    for (int ch = 0; ch < 4; ch++) begin
      expCnt[ch] = 0; expSkew[ch] = 0; expFok[ch] = 1'b0; expSok[ch] = 1'b0;
    end
    if (expTo) begin
      expDone = t + TO + 1;
    end else begin
      expDone = s + 2 + G;
      for (int ch = 0; ch < 4; ch++) begin
        cnt = 0;
        for (longint r = s; r < s + G; r++) if (rise(ch, r)) cnt++;
        expCnt[ch] = cnt;
        expFok[ch] = (cnt >= 95) && (cnt <= 105);
      end
      for (int n = 1; n < 4; n++) begin
        found = 1'b0;
        sk = G;
        for (longint r = s + 1; r < s + G && !found; r++)
          if (rise(n, r)) begin
            sk = int'(r - s);
            found = 1'b1;
          end
        if (sk > SKEW_SAT) sk = SKEW_SAT;
        expSkew[n] = sk;
        expSok[n]  = found && sk != SKEW_SAT && sk >= 1 && sk <= 4;
      end
    end
  endtask

  task automatic setWave(input int p0, d0, p1, d1, p2, d2, p3, d3);
    perCh[0] = p0; dlyCh[0] = d0; perCh[1] = p1; dlyCh[1] = d1;
    perCh[2] = p2; dlyCh[2] = d2; perCh[3] = p3; dlyCh[3] = d3;
  endtask

  task automatic runTrial(input string name, input bit pokeBusy, input bit clrAtDone);
    longint t, c, doneCyc;
    bit     seen, failA, failB;
    repeat (12) @(negedge clkIn);
    t = cycNow();
    startIn = 1'b1;
    modelRun(t);
    @(negedge clkIn);
    startIn = 1'b0;
    seen = 1'b0;
    doneCyc = -1;
    for (int i = 0; i < 2 * G && !seen; i++) begin
      c = cycNow();
      startIn  = pokeBusy && (c == t + 100);
      clrErrIn = clrAtDone && (c == expDone);
      if (doneA) begin
        seen = 1'b1;
        doneCyc = c;
      end else begin
        @(negedge clkIn);
      end
    end
    check({name, " doneSeen"}, seen, 1);
    if (seen) begin
      check({name, " doneCycle"}, doneCyc, expDone);
      check({name, " doneB"}, doneB, 1);
      check({name, " busyAtDone"}, busyA, 1);
      check({name, " timeoutA"}, toA, expTo);
      check({name, " timeoutB"}, toB, expTo);
      check({name, " cntA"}, cntA, {16'(expCnt[1]), 16'(expCnt[0])});
      check({name, " cntB"}, cntB, {16'(expCnt[3]), 16'(expCnt[2]), 16'(expCnt[1]), 16'(expCnt[0])});
      check({name, " freqOkA"}, fokA, {expFok[1], expFok[0]});
      check({name, " freqOkB"}, fokB, {expFok[3], expFok[2], expFok[1], expFok[0]});
      check({name, " skewA"}, skA, 8'(expSkew[1]));
      check({name, " skewB"}, skB, {8'(expSkew[3]), 8'(expSkew[2]), 8'(expSkew[1])});
      check({name, " skewOkA"}, sokA, expSok[1]);
      check({name, " skewOkB"}, sokB, {expSok[3], expSok[2], expSok[1]});
      failA = expTo || !(expFok[0] && expFok[1]) || !expSok[1];
      failB = failA || !(expFok[2] && expFok[3]) || !(expSok[2] && expSok[3]);
      errExpA = StickyEn && (failA || (errExpA && !clrAtDone));
      errExpB = StickyEn && (failB || (errExpB && !clrAtDone));
      startIn = 1'b1;
    end
    @(negedge clkIn);
    startIn  = 1'b0;
    clrErrIn = 1'b0;
    if (seen) begin
      check({name, " busyAfterDone"}, busyA, 0);
      check({name, " donePulse"}, doneA, 0);
      check({name, " errA"}, errA, errExpA);
      check({name, " errB"}, errB, errExpB);
      @(negedge clkIn);
      check({name, " startInDoneIgnored"}, {busyA, busyB}, 0);
      check({name, " cntHeld"}, cntA, {16'(expCnt[1]), 16'(expCnt[0])});
    end
  endtask

  task automatic pulseClr(input string name);
    @(negedge clkIn);
    clrErrIn = 1'b1;
    @(negedge clkIn);
    clrErrIn = 1'b0;
    errExpA = 1'b0;
    errExpB = 1'b0;
    check({name, " errAfterClrA"}, errA, errExpA);
    check({name, " errAfterClrB"}, errB, errExpB);
  endtask

  task automatic resetMidMeasure();
    bit sawDone;
    sawDone = 1'b0;
    repeat (12) @(negedge clkIn);
    startIn = 1'b1;
    @(negedge clkIn);
    startIn = 1'b0;
    repeat (120) @(negedge clkIn);
    check("rst busyBefore", busyA, 1);
    rstBIn = 1'b0;
    #1;
    check("rst ctrlA", {busyA, doneA, toA, errA}, 0);
    check("rst resultsA", {cntA, fokA, skA, sokA}, 0);
    check("rst outputsB", {busyB, doneB, toB, errB, cntB, fokB, skB, sokB}, 0);
    errExpA = 1'b0;
    errExpB = 1'b0;
    repeat (3) @(negedge clkIn);
    rstBIn = 1'b1;
    for (int i = 0; i < G + 50; i++) begin
      @(negedge clkIn);
      if (doneA || busyA || doneB) sawDone = 1'b1;
    end
    check("rst noDoneAfter", sawDone, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rstBIn = 1'b0;
    startIn = 1'b0;
    clrErrIn = 1'b0;
    setWave(8, 0, 8, 3, 8, 1, 8, 2);
    repeat (5) @(negedge clkIn);
    check("reset ctrlA", {busyA, doneA, toA, errA}, 0);
    check("reset resultsA", {cntA, fokA, skA, sokA}, 0);
    check("reset outputsB", {busyB, doneB, toB, errB, cntB, fokB, skB, sokB}, 0);
    rstBIn = 1'b1;

    runTrial("nominal", 1'b0, 1'b0);
    setWave(8, 0, 8, 6, 8, 2, 8, 4);
    runTrial("skew6", 1'b0, 1'b0);
    pulseClr("skew6");
    setWave(8, 0, 10, 3, 8, 1, 8, 2);
    runTrial("period10", 1'b0, 1'b0);
    pulseClr("period10");
    setWave(0, 0, 8, 3, 8, 1, 8, 2);
    runTrial("timeout", 1'b0, 1'b1);
    setWave(8, 0, 8, 1, 8, 2, 8, 4);
    runTrial("fourCh", 1'b1, 1'b0);
    pulseClr("fourCh");
    setWave(8, 5, 8, 5, 8, 7, 8, 1);
    runTrial("simultaneous", 1'b0, 1'b0);
    resetMidMeasure();
    setWave(8, 0, 8, 3, 8, 1, 8, 2);
    runTrial("afterReset", 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      perCh[0] = $urandom_range(9, 7);
      dlyCh[0] = $urandom_range(perCh[0] - 1, 0);
      for (int ch = 1; ch < 4; ch++) begin
        p = $urandom_range(12, 6);
        perCh[ch] = p;
        dlyCh[ch] = $urandom_range(p - 1, 0);
      end
      runTrial($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
